// File: rtl/pipeline_sequencer_pkg.sv
// Shared state encodings and pipeline-register control words for the run/step/halt sequencer.
package pipeline_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // EX, MEM and WB must empty before the machine counts as halted.
  localparam int unsigned DRAIN_CYCLES_DEF = 3;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
  } ctl_t;

  // A bubble freezes PC and IF/ID while ID/EX captures all-zero control.
  localparam ctl_t CTL_HOLD    = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                   id_ex_write: 1'b0, id_ex_flush: 1'b0};
  localparam ctl_t CTL_BUBBLE  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                   id_ex_write: 1'b1, id_ex_flush: 1'b1};
  localparam ctl_t CTL_BRANCH  = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                   id_ex_write: 1'b1, id_ex_flush: 1'b0};
  localparam ctl_t CTL_ADVANCE = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                   id_ex_write: 1'b1, id_ex_flush: 1'b0};

endpackage

// File: rtl/pipeline_sequencer_rise_detect.sv
// Rising-edge detector for an already-synchronised level input.
module pipeline_sequencer_rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prev_q <= 1'b0;
    else        prev_q <= level_i;
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt controller: turns exec, step mode, HLT, load-use and branch events
// into PC, IF/ID and ID/EX write enables and flushes, and counts load-use stalls.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 exec,
  input  logic                 step_mode,
  input  logic                 halt_id,
  input  logic                 load_use_hazard,
  input  logic                 branch_taken,
  output logic                 op_pc_write,
  output logic                 op_if_id_write,
  output logic                 op_if_id_flush,
  output logic                 op_id_ex_write,
  output logic                 op_id_ex_flush,
  output logic                 running,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [2:0]           state
);

  localparam int unsigned DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e               state_q, state_d;
  logic [DCW-1:0]       drain_q, drain_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic                 exec_rise;
  ctl_t                 ctl;

  pipeline_sequencer_rise_detect u_rise (
    .clock   (clock),
    .reset   (reset),
    .level_i (exec),
    .rise_o  (exec_rise)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    stall_d = stall_q;
    ctl     = CTL_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (exec_rise) state_d = step_mode ? ST_STEP : ST_RUN;
      end
      ST_RUN, ST_STEP: begin
        if (halt_id) begin
          ctl     = CTL_BUBBLE;
          state_d = ST_DRAIN;
          drain_d = DCW'(DRAIN_CYCLES);
        end else begin
          if (load_use_hazard) begin
            ctl = CTL_BUBBLE;
            if (stall_q != '1) stall_d = stall_q + 1'b1;
          end else if (branch_taken) begin
            ctl = CTL_BRANCH;
          end else begin
            ctl = CTL_ADVANCE;
          end
          // A pause still lets this cycle advance; a step only completes on a non-stall cycle.
          if (state_q == ST_RUN) begin
            if (exec_rise) state_d = ST_IDLE;
          end else if (!load_use_hazard) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        ctl = CTL_BUBBLE;
        if (drain_q != '0) drain_d = drain_q - 1'b1;
        if (drain_q <= DCW'(1)) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        ctl = CTL_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  assign op_pc_write    = ctl.pc_write;
  assign op_if_id_write = ctl.if_id_write;
  assign op_if_id_flush = ctl.if_id_flush;
  assign op_id_ex_write = ctl.id_ex_write;
  assign op_id_ex_flush = ctl.id_ex_flush;
  assign running        = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign halted         = (state_q == ST_HALTED);
  assign stall_count    = stall_q;
  assign state          = state_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed vector table, hand-built corner sequences,
// then random stimulus against a cycle-level behavioural model.
module tb_pipeline_sequencer;

  localparam int CW     = 4;
  localparam int DRAIN  = 3;
  localparam int SATMAX = (1 << CW) - 1;

  logic          clock, reset;
  logic          exec, step_mode, halt_id, load_use_hazard, branch_taken;
  logic          op_pc_write, op_if_id_write, op_if_id_flush, op_id_ex_write, op_id_ex_flush;
  logic          running, halted;
  logic [CW-1:0] stall_count;
  logic [2:0]    state;
  logic [4:0]    ops;

  int errors = 0;
  int checks = 0;

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_WIDTH(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .exec            (exec),
    .step_mode       (step_mode),
    .halt_id         (halt_id),
    .load_use_hazard (load_use_hazard),
    .branch_taken    (branch_taken),
    .op_pc_write     (op_pc_write),
    .op_if_id_write  (op_if_id_write),
    .op_if_id_flush  (op_if_id_flush),
    .op_id_ex_write  (op_id_ex_write),
    .op_id_ex_flush  (op_id_ex_flush),
    .running         (running),
    .halted          (halted),
    .stall_count     (stall_count),
    .state           (state)
  );

  // ops bit order: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush}
  assign ops = {op_pc_write, op_if_id_write, op_if_id_flush, op_id_ex_write, op_id_ex_flush};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Behavioural model: mode numbers are the LED codes (0 idle, 1 run, 2 step, 3 drain, 4 halted).
  int m_state, m_drain_left, m_stall;
  bit m_prev;

  function automatic void model_reset();
    m_state = 0; m_drain_left = 0; m_stall = 0; m_prev = 1'b0;
  endfunction

  function automatic logic [4:0] model_ops(input bit hl, input bit lu, input bit br);
    if (m_state == 3) return 5'b00011;
    if (m_state != 1 && m_state != 2) return 5'b00000;
    if (hl || lu) return 5'b00011;
    if (br) return 5'b11110;
    return 5'b11010;
  endfunction

  function automatic void model_step(input bit ex, input bit sm, input bit hl, input bit lu, input bit br);
    bit rise;
    rise   = ex && !m_prev;
    m_prev = ex;
    if (m_state == 0) begin
      if (rise) m_state = sm ? 2 : 1;
    end else if (m_state == 1 || m_state == 2) begin
      if (hl) begin
        m_state = 3; m_drain_left = DRAIN;
      end else begin
        if (lu && m_stall < SATMAX) m_stall++;
        if (m_state == 1 && rise) m_state = 0;
        else if (m_state == 2 && !lu) m_state = 0;
      end
    end else if (m_state == 3) begin
      m_drain_left--;
      if (m_drain_left == 0) m_state = 4;
    end
  endfunction

  task automatic check_model(input string tag, input logic [4:0] eops);
    chk({tag, " ops"}, ops, eops);
    chk({tag, " state"}, state, m_state);
    chk({tag, " run/halt"}, {running, halted}, {(m_state == 1 || m_state == 2), (m_state == 4)});
    chk({tag, " stalls"}, stall_count, m_stall);
  endtask

  task automatic drive(input bit ex, input bit sm, input bit hl, input bit lu, input bit br);
    @(negedge clock);
    exec = ex; step_mode = sm; halt_id = hl; load_use_hazard = lu; branch_taken = br;
    #2;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    exec = 1'b0; step_mode = 1'b0; halt_id = 1'b0; load_use_hazard = 1'b0; branch_taken = 1'b0;
    #1;
    model_reset();
    check_model("reset", 5'b00000);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    bit         ex, sm, hl, lu, br;
    logic [4:0] eops;
    int         est;
    int         estall;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input bit ex, input bit sm, input bit hl, input bit lu, input bit br,
                              input logic [4:0] eops, input int est, input int estall);
    vec_t v;
    v.ex = ex; v.sm = sm; v.hl = hl; v.lu = lu; v.br = br;
    v.eops = eops; v.est = est; v.estall = estall;
    return v;
  endfunction

  initial begin
    bit ex_l, sm_l, hl_r, lu_r, br_r;
    logic [4:0] eops;

    // State and stall count shown are the values present while the vector is applied.
    tbl[0]  = mk(0, 0, 0, 0, 0, 5'b00000, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 5'b00000, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 5'b11010, 1, 0);
    tbl[3]  = mk(0, 0, 0, 1, 0, 5'b00011, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 5'b11010, 1, 1);
    tbl[5]  = mk(0, 0, 0, 1, 1, 5'b00011, 1, 1);
    tbl[6]  = mk(0, 0, 0, 0, 1, 5'b11110, 1, 2);
    tbl[7]  = mk(1, 0, 0, 0, 0, 5'b11010, 1, 2);
    tbl[8]  = mk(0, 0, 0, 0, 0, 5'b00000, 0, 2);
    tbl[9]  = mk(1, 1, 0, 0, 0, 5'b00000, 0, 2);
    tbl[10] = mk(0, 1, 0, 1, 0, 5'b00011, 2, 2);
    tbl[11] = mk(0, 1, 0, 1, 0, 5'b00011, 2, 3);
    tbl[12] = mk(0, 1, 0, 0, 0, 5'b11010, 2, 4);
    tbl[13] = mk(0, 1, 0, 0, 0, 5'b00000, 0, 4);
    tbl[14] = mk(1, 0, 0, 0, 0, 5'b00000, 0, 4);
    tbl[15] = mk(0, 0, 1, 1, 1, 5'b00011, 1, 4);
    tbl[16] = mk(1, 0, 0, 1, 0, 5'b00011, 3, 4);
    tbl[17] = mk(0, 0, 0, 0, 0, 5'b00011, 3, 4);
    tbl[18] = mk(0, 0, 0, 0, 0, 5'b00011, 3, 4);
    tbl[19] = mk(0, 0, 0, 0, 0, 5'b00000, 4, 4);
    tbl[20] = mk(1, 0, 0, 0, 0, 5'b00000, 4, 4);
    tbl[21] = mk(0, 0, 0, 0, 0, 5'b00000, 4, 4);

    reset = 1'b0;
    exec = 1'b0; step_mode = 1'b0; halt_id = 1'b0; load_use_hazard = 1'b0; branch_taken = 1'b0;
    #3;
    chk("reset ops", ops, 5'b00000);
    chk("reset state", state, 3'd0);
    chk("reset run/halt", {running, halted}, 2'b00);
    chk("reset stalls", stall_count, 0);
    @(posedge clock);
    #1 reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].ex, tbl[i].sm, tbl[i].hl, tbl[i].lu, tbl[i].br);
      chk($sformatf("vec%0d ops", i), ops, tbl[i].eops);
      chk($sformatf("vec%0d state", i), state, tbl[i].est);
      chk($sformatf("vec%0d halted", i), halted, (tbl[i].est == 4));
      chk($sformatf("vec%0d stalls", i), stall_count, tbl[i].estall);
    end

    // Asynchronous reset in the second DRAIN cycle.
    pulse_reset();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("drain1 state", state, 3'd3);
    drive(0, 0, 0, 0, 0);
    chk("drain2 state", state, 3'd3);
    chk("drain2 ops", ops, 5'b00011);
    chk("drain2 stalls", stall_count, 1);
    reset = 1'b0;
    #1;
    chk("abort ops", ops, 5'b00000);
    chk("abort state", state, 3'd0);
    chk("abort stalls", stall_count, 0);
    chk("abort run/halt", {running, halted}, 2'b00);
    @(posedge clock);
    #1 reset = 1'b1;

    // Stall counter saturates at all-ones.
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) drive(0, 0, 0, 1, 0);
    chk("sat stalls", stall_count, SATMAX);
    chk("sat ops", ops, 5'b00011);
    chk("sat state", state, 3'd1);
    drive(0, 0, 0, 0, 0);
    chk("sat hold", stall_count, SATMAX);

    // Random stimulus against the model.
    pulse_reset();
    ex_l = 1'b0;
    sm_l = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ((m_state == 4 && $urandom_range(0, 3) == 0) || $urandom_range(0, 249) == 0) begin
        pulse_reset();
      end else begin
        if ($urandom_range(0, 2) == 0) ex_l = ~ex_l;
        if ($urandom_range(0, 15) == 0) sm_l = ~sm_l;
        hl_r = ($urandom_range(0, 39) == 0);
        lu_r = ($urandom_range(0, 3) == 0);
        br_r = ($urandom_range(0, 3) == 0);
        drive(ex_l, sm_l, hl_r, lu_r, br_r);
        eops = model_ops(hl_r, lu_r, br_r);
        check_model("rand", eops);
        model_step(ex_l, sm_l, hl_r, lu_r, br_r);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Global run/step/halt controller for the 5-stage 16-bit pipeline.
- Combines the exec button, single-step mode, HLT detected in ID, load-use hazard and taken branch into the pipeline-register write enables and flushes.
- Sits beside the decode stage. Drives PC, IF/ID and ID/EX register control and replaces the ad-hoc gating of those enables.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN after HLT (EX, MEM, WB) before asserting halted.
- CNT_WIDTH, 16, width of the stall performance counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- exec  in  1  run/pause button level, already synchronised.
- step_mode  in  1  1 = each exec press advances one instruction.
- halt_id  in  1  HLT instruction decoded in ID this cycle.
- load_use_hazard  in  1  EX is a load whose destination matches ID rs/rd.
- branch_taken  in  1  branch resolved taken in ID this cycle.
- op_pc_write  out  1  PC update enable.
- op_if_id_write  out  1  IF/ID register enable.
- op_if_id_flush  out  1  IF/ID clears to NOP.
- op_id_ex_write  out  1  ID/EX register enable.
- op_id_ex_flush  out  1  ID/EX loads a bubble (all control zero).
- running  out  1  state is RUN or STEP.
- halted  out  1  state is HALTED.
- stall_count  out  CNT_WIDTH  load-use stall cycles since reset.
- state  out  3  current state, for the LED display.

Behaviour:
- Reset (reset=0, async): state=IDLE, exec_prev=0, drain counter=0, stall_count=0. All op_* outputs=0, running=0, halted=0.
- exec_rise = exec & ~exec_prev. exec_prev is registered every cycle.
- State encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. Unused codes go to IDLE on the next clock.
- IDLE:
  - All enables 0.
  - On exec_rise: go to STEP if step_mode=1, else RUN.
- An advance cycle is any cycle in RUN or STEP. Outputs are combinational from state and inputs (Mealy), with priority in this order:
  1. halt_id: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1. Next state DRAIN; counter loads DRAIN_CYCLES.
  2. load_use_hazard: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1. stall_count increments, saturating at all-ones.
  3. branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_write=1.
  4. Otherwise: pc_write=1, if_id_write=1, id_ex_write=1, both flushes 0.
- RUN:
  - exec_rise without halt_id goes to IDLE (pause). The current cycle still advances.
  - halt_id wins over exec_rise.
- STEP:
  - Stays in STEP while load_use_hazard is active, so a stall cycle does not count as the step.
  - The first cycle resolved by rule 3 or 4 returns to IDLE.
  - Rule 1 goes to DRAIN.
- DRAIN:
  - pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1.
  - Counter decrements each cycle. When counter=1, next state is HALTED.
  - exec, hazard and branch inputs are ignored.
- HALTED:
  - All enables 0, halted=1.
  - Only reset leaves HALTED; exec_rise is ignored.
- Simultaneous inputs resolve by the priority list above.
- Reset asserted mid-DRAIN aborts immediately to IDLE.
- stall_count does not increment in IDLE, DRAIN or HALTED.

Decomposition:
- Shared constants include file:
  - State encodings.
  - DRAIN_CYCLES default.
  - Flush/bubble encoding.
- One natural sub-module: rise_detect (registered previous level, outputs exec_rise, same async active-low reset).
- Everything else lives in one FSM plus the counter logic.

Test Plan:
1. Reset, exec pulse with step_mode=0 -> state=1. Next cycle pc_write=if_id_write=id_ex_write=1, flushes 0.
2. RUN, load_use_hazard=1 for 1 cycle -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1. stall_count goes 0->1. Next cycle normal.
3. RUN, branch_taken=1 and load_use_hazard=1 together -> stall wins: if_id_flush=0, pc_write=0. With branch_taken=1 alone -> if_id_flush=1, pc_write=1.
4. step_mode=1, exec pulse with load_use_hazard high for 2 cycles -> STEP holds 2 stall cycles, advances once, returns to IDLE. stall_count=2.
5. RUN, halt_id=1 -> DRAIN for exactly 3 cycles with id_ex_flush=1. Then halted=1, state=4. A further exec pulse leaves state=4.
6. Reset asserted asynchronously in the 2nd DRAIN cycle -> outputs 0 immediately, state=0, stall_count=0.
